tile_sequencer: RTL and testbench
=================================

TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameter Dhv_SIZE, default 4000, hypervector dimension (projection rows).
REQ-002 Parameter Div_SIZE, default 512, input feature count.
REQ-003 Parameter N_SIZE, default 16, features consumed per MAC tile.
REQ-004 Parameter M_SIZE, default 16, hypervector rows produced per row-block.
REQ-005 Port clk  in  1  single clock; all logic on posedge.
REQ-006 Port reset_in  in  1  synchronous, active-high reset.
REQ-007 Port start  in  1  request encoding of one sample; honoured only in IDLE.
REQ-008 Port abort  in  1  terminate the current encoding; return to IDLE.
REQ-009 Port tile_x  out  XW=$clog2(Div_SIZE)  feature offset of the current tile (multiple of N_SIZE).
REQ-010 Port tile_y  out  YW=$clog2(Dhv_SIZE)  row offset of the current row-block (multiple of M_SIZE).
REQ-011 Port tile_valid  out  1  tile_x/tile_y are valid for the MAC.
REQ-012 Port tile_ready  in  1  MAC accepts the tile this cycle.
REQ-013 Port mac_clear  out  1  one-cycle pulse that clears the MAC accumulators.
REQ-014 Port mac_done  in  1  MAC results for the current row-block are complete.
REQ-015 Port row_done  out  1  one-cycle pulse when a row-block is committed.
REQ-016 Port all_done  out  1  one-cycle pulse when every row-block is committed.
REQ-017 Port busy  out  1  high in every state except IDLE.
REQ-018 Port err  out  1  sticky flag: mac_done was received outside WAIT_DONE.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, ISSUE, WAIT_DONE and FINISH, all registered.
REQ-020 IDLE: on start go to CLEAR, set tile_y=0, clear err.
REQ-021 CLEAR: assert mac_clear for exactly one cycle, set tile_x=0, then go to ISSUE.
REQ-022 ISSUE: hold tile_valid high; on tile_valid&&tile_ready, go to WAIT_DONE if tile_x==Div_SIZE-N_SIZE, otherwise add N_SIZE to tile_x.
REQ-023 While tile_ready is low, tile_x, tile_y and tile_valid SHALL hold unchanged.
REQ-024 WAIT_DONE: on mac_done, pulse row_done; then go to FINISH if tile_y==Dhv_SIZE-M_SIZE, otherwise add M_SIZE to tile_y and go to CLEAR.
REQ-025 FINISH: pulse all_done for one cycle, then go to IDLE.
REQ-026 Latency: start sampled at cycle 0 -> mac_clear in cycle 1 -> first tile_valid in cycle 2.
REQ-027 Row-block cost with tile_ready always high: 1 + Div_SIZE/N_SIZE cycles, plus the wait for mac_done.
REQ-028 start outside IDLE is ignored, including in FINISH.
REQ-029 mac_done outside WAIT_DONE is ignored for sequencing and sets err.
REQ-030 abort (any state except IDLE) forces IDLE on the next edge; outputs take reset values except err; no row_done or all_done is issued.
REQ-031 abort and mac_done in the same cycle: abort wins; no row_done.
REQ-032 Offset arithmetic is unsigned; tile_x and tile_y SHALL never exceed Div_SIZE-N_SIZE and Dhv_SIZE-M_SIZE respectively.
REQ-033 Elaboration SHALL fail unless Div_SIZE%N_SIZE==0 and Dhv_SIZE%M_SIZE==0.

Reset
REQ-034 While reset_in is high: state=IDLE; tile_x, tile_y, tile_valid, mac_clear, row_done, all_done, busy and err are 0.
REQ-035 reset_in mid-operation behaves as abort and also clears err; reset_in overrides start and abort.

Structure
REQ-036 The state enum and the default size constants SHALL live in the shared package hd_pkg.
REQ-037 One sub-module, tile_counter (wrapping offset counter with load, increment and terminal flag), SHALL be instantiated twice: once for x, once for y.
REQ-038 All outputs SHALL be driven from registers.

Verification (Div_SIZE=64, N_SIZE=16, Dhv_SIZE=48, M_SIZE=16)
REQ-039 Start, tile_ready=1, mac_done 2 cycles after the last tile -> tile_x sequence 0,16,32,48 for each tile_y 0,16,32; 3 row_done, 1 all_done; busy falls after all_done.
REQ-040 tile_ready low for 3 cycles while tile_x=16 -> tile_x holds 16, tile_valid stays high, no tile is skipped.
REQ-041 start pulsed during ISSUE and during FINISH -> no restart; the sequence is unchanged; IDLE is reached once.
REQ-042 mac_done pulsed during ISSUE -> err=1 and remains 1; the sequence completes normally; the next accepted start clears err.
REQ-043 abort while tile_y=16 -> IDLE next cycle; no further row_done or all_done; a fresh start begins at tile_y=0.
REQ-044 reset_in asserted in WAIT_DONE together with mac_done -> all outputs 0 next cycle; no row_done.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared definitions for the hypervector encoder: default projection sizes,
// the tile sequencer state encoding and an offset-width helper.
package hd_pkg;

    localparam int DHV_SIZE_DEF = 4000;
    localparam int DIV_SIZE_DEF = 512;
    localparam int N_SIZE_DEF   = 16;
    localparam int M_SIZE_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT_DONE,
        FINISH
    } seq_state_t;

    // Width of an offset register spanning 0..size-1; never narrower than one bit.
    function automatic int offset_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/tile_sequencer_if.sv
// Tile handshake between the sequencer (master) and the MAC array (slave).
interface tile_sequencer_if import hd_pkg::*; #(
    parameter int XW = offset_w(DIV_SIZE_DEF),
    parameter int YW = offset_w(DHV_SIZE_DEF)
) ();

    logic [XW-1:0] tile_x;
    logic [YW-1:0] tile_y;
    logic          tile_valid;
    logic          tile_ready;
    logic          mac_clear;
    logic          mac_done;

    modport master (
        output tile_x,
        output tile_y,
        output tile_valid,
        output mac_clear,
        input  tile_ready,
        input  mac_done
    );

    modport slave (
        input  tile_x,
        input  tile_y,
        input  tile_valid,
        input  mac_clear,
        output tile_ready,
        output mac_done
    );

endinterface

// File: rtl/tile_counter.sv
// Offset counter stepping by STEP from 0 to LAST, wrapping back to 0 on the
// increment after LAST; load forces 0 and has priority over increment.
module tile_counter #(
    parameter int W    = 4,
    parameter int STEP = 1,
    parameter int LAST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         term
);

    localparam logic [W-1:0] STEP_V = W'(STEP);
    localparam logic [W-1:0] LAST_V = W'(LAST);

    assign term = (count == LAST_V);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (inc) begin
            count <= term ? '0 : count + STEP_V;
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// Walks the projection matrix tile by tile: for every row-block it clears the
// MAC, issues all feature tiles, then waits for the MAC to report completion.
module tile_sequencer import hd_pkg::*; #(
    parameter int Dhv_SIZE = DHV_SIZE_DEF,
    parameter int Div_SIZE = DIV_SIZE_DEF,
    parameter int N_SIZE   = N_SIZE_DEF,
    parameter int M_SIZE   = M_SIZE_DEF
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             abort,
    tile_sequencer_if.master mac,
    output logic             row_done,
    output logic             all_done,
    output logic             busy,
    output logic             err
);

    localparam int XW = offset_w(Div_SIZE);
    localparam int YW = offset_w(Dhv_SIZE);

    generate
        if ((Div_SIZE % N_SIZE) != 0) begin : g_bad_div
            $error("tile_sequencer: Div_SIZE must be a multiple of N_SIZE");
        end
        if ((Dhv_SIZE % M_SIZE) != 0) begin : g_bad_dhv
            $error("tile_sequencer: Dhv_SIZE must be a multiple of M_SIZE");
        end
    endgenerate

    seq_state_t    state;
    logic          tile_valid_r;
    logic          mac_clear_r;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          x_term;
    logic          y_term;
    logic          abort_act;
    logic          tile_acc;
    logic          x_load;
    logic          x_inc;
    logic          y_load;
    logic          y_inc;

    assign abort_act = abort && (state != IDLE);
    assign tile_acc  = (state == ISSUE) && tile_valid_r && mac.tile_ready;

    // Abort returns both offsets to zero through the counter load path.
    assign x_load = abort_act || (state == CLEAR);
    assign x_inc  = tile_acc;
    assign y_load = abort_act || ((state == IDLE) && start);
    assign y_inc  = (state == WAIT_DONE) && mac.mac_done;

    tile_counter #(
        .W    (XW),
        .STEP (N_SIZE),
        .LAST (Div_SIZE - N_SIZE)
    ) u_x_cnt (
        .clk   (clk),
        .rst   (reset_in),
        .load  (x_load),
        .inc   (x_inc),
        .count (x_cnt),
        .term  (x_term)
    );

    tile_counter #(
        .W    (YW),
        .STEP (M_SIZE),
        .LAST (Dhv_SIZE - M_SIZE)
    ) u_y_cnt (
        .clk   (clk),
        .rst   (reset_in),
        .load  (y_load),
        .inc   (y_inc),
        .count (y_cnt),
        .term  (y_term)
    );

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state        <= IDLE;
            tile_valid_r <= 1'b0;
            mac_clear_r  <= 1'b0;
            row_done     <= 1'b0;
            all_done     <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            mac_clear_r <= 1'b0;
            row_done    <= 1'b0;
            all_done    <= 1'b0;
            if (abort_act) begin
                state        <= IDLE;
                tile_valid_r <= 1'b0;
                busy         <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= CLEAR;
                            mac_clear_r <= 1'b1;
                            busy        <= 1'b1;
                            err         <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        state        <= ISSUE;
                        tile_valid_r <= 1'b1;
                    end
                    ISSUE: begin
                        if (tile_acc && x_term) begin
                            state        <= WAIT_DONE;
                            tile_valid_r <= 1'b0;
                        end
                    end
                    WAIT_DONE: begin
                        if (mac.mac_done) begin
                            row_done <= 1'b1;
                            if (y_term) begin
                                state    <= FINISH;
                                all_done <= 1'b1;
                            end else begin
                                state       <= CLEAR;
                                mac_clear_r <= 1'b1;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state        <= IDLE;
                        tile_valid_r <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
            // A completion outside WAIT_DONE is a protocol error; it stays flagged until the next start.
            if (mac.mac_done && (state != WAIT_DONE)) begin
                err <= 1'b1;
            end
        end
    end

    assign mac.tile_x     = x_cnt;
    assign mac.tile_y     = y_cnt;
    assign mac.tile_valid = tile_valid_r;
    assign mac.mac_clear  = mac_clear_r;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with Div_SIZE=64, N_SIZE=16, Dhv_SIZE=48, M_SIZE=16.
module tb_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_in;
    logic start;
    logic abort;
    logic row_done;
    logic all_done;
    logic busy;
    logic err;

    tile_sequencer_if #(.XW(6), .YW(6)) mac ();

    tile_sequencer #(
        .Dhv_SIZE (48),
        .Div_SIZE (64),
        .N_SIZE   (16),
        .M_SIZE   (16)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .start    (start),
        .abort    (abort),
        .mac      (mac),
        .row_done (row_done),
        .all_done (all_done),
        .busy     (busy),
        .err      (err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] acc_q[$];
    logic [11:0] exp_q[$];
    int          n_row = 0;
    int          n_all = 0;
    int          n_clr = 0;
    int          n_fall = 0;
    int          n_busy_after_all = 0;
    logic        prev_busy = 1'b0;
    logic        prev_all = 1'b0;
    bit          auto_done = 1'b1;
    bit          pending_last = 1'b0;
    int          done_cd = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observe accepted tiles and output pulses mid-cycle.
    always @(negedge clk) begin
        if (mac.tile_valid === 1'b1 && mac.tile_ready === 1'b1) begin
            acc_q.push_back({mac.tile_y, mac.tile_x});
            if (auto_done && mac.tile_x == 6'd48) pending_last = 1'b1;
        end
        if (row_done === 1'b1) n_row++;
        if (all_done === 1'b1) n_all++;
        if (mac.mac_clear === 1'b1) n_clr++;
        if (prev_busy && busy === 1'b0) n_fall++;
        if (prev_all && busy === 1'b0) n_busy_after_all++;
        prev_busy = (busy === 1'b1);
        prev_all  = (all_done === 1'b1);
    end

    // One clock; pulse inputs drop, and the MAC model raises mac_done two cycles after the last tile.
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (pending_last) begin
            pending_last = 1'b0;
            done_cd = 2;
        end else if (done_cd > 0) begin
            done_cd--;
        end
        mac.mac_done = (done_cd == 1);
    endtask

    task automatic clear_stats();
        acc_q.delete();
        n_row = 0;
        n_all = 0;
        n_clr = 0;
        n_fall = 0;
        n_busy_after_all = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 200);
        check_eq({tag, "_idle"}, busy, 0);
        step();
    endtask

    task automatic check_seq(input string tag);
        check_eq({tag, "_ntiles"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            check_eq($sformatf("%s_tile%0d", tag, i), acc_q[i], exp_q[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tile_x"}, mac.tile_x, 0);
        check_eq({tag, "_tile_y"}, mac.tile_y, 0);
        check_eq({tag, "_tile_valid"}, mac.tile_valid, 0);
        check_eq({tag, "_mac_clear"}, mac.mac_clear, 0);
        check_eq({tag, "_row_done"}, row_done, 0);
        check_eq({tag, "_all_done"}, all_done, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_in = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mac.tile_ready = 1'b0;
        mac.mac_done = 1'b0;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                exp_q.push_back({6'(y * 16), 6'(x * 16)});
            end
        end

        repeat (3) step();
        check_all_zero("rst");
        reset_in = 1'b0;
        mac.tile_ready = 1'b1;
        step();

        // Full encoding with tile_ready held high.
        clear_stats();
        start = 1'b1;
        step();
        check_eq("t1_mac_clear", mac.mac_clear, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_valid_c1", mac.tile_valid, 0);
        step();
        check_eq("t1_valid_c2", mac.tile_valid, 1);
        check_eq("t1_x_c2", mac.tile_x, 0);
        check_eq("t1_clear_c2", mac.mac_clear, 0);
        wait_idle("t1");
        check_seq("t1");
        check_eq("t1_rows", n_row, 3);
        check_eq("t1_all", n_all, 1);
        check_eq("t1_clears", n_clr, 3);
        check_eq("t1_busy_after_all", n_busy_after_all, 1);
        check_eq("t1_err", err, 0);

        // Backpressure while tile_x=16.
        clear_stats();
        start = 1'b1;
        step();
        step();
        step();
        mac.tile_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("t2_hold_x%0d", i), mac.tile_x, 16);
            check_eq($sformatf("t2_hold_v%0d", i), mac.tile_valid, 1);
        end
        mac.tile_ready = 1'b1;
        wait_idle("t2");
        check_seq("t2");
        check_eq("t2_rows", n_row, 3);

        // start in ISSUE and in FINISH is ignored.
        clear_stats();
        start = 1'b1;
        step();
        step();
        start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (all_done) start = 1'b1;
        end while (busy && n < 200);
        check_eq("t3_idle", busy, 0);
        step();
        step();
        check_eq("t3_no_restart", busy, 0);
        check_eq("t3_idle_once", n_fall, 1);
        check_eq("t3_all", n_all, 1);
        check_eq("t3_rows", n_row, 3);
        check_seq("t3");

        // Stray mac_done during ISSUE sets a sticky err.
        clear_stats();
        start = 1'b1;
        step();
        step();
        mac.mac_done = 1'b1;
        step();
        check_eq("t4_err_set", err, 1);
        wait_idle("t4");
        check_eq("t4_err_sticky", err, 1);
        check_eq("t4_rows", n_row, 3);
        check_seq("t4");
        start = 1'b1;
        step();
        check_eq("t4_err_cleared", err, 0);
        check_eq("t4_busy", busy, 1);
        abort = 1'b1;
        step();
        check_eq("t4_abort_busy", busy, 0);

        // Abort during the second row-block.
        step();
        clear_stats();
        start = 1'b1;
        step();
        n = 0;
        do begin
            step();
            n++;
        end while (!(mac.tile_y == 6'd16 && mac.tile_valid) && n < 200);
        check_eq("t5_reach_y", mac.tile_y, 16);
        abort = 1'b1;
        step();
        check_eq("t5_busy", busy, 0);
        check_eq("t5_valid", mac.tile_valid, 0);
        check_eq("t5_x", mac.tile_x, 0);
        check_eq("t5_y", mac.tile_y, 0);
        repeat (8) step();
        check_eq("t5_rows", n_row, 1);
        check_eq("t5_all", n_all, 0);
        clear_stats();
        start = 1'b1;
        step();
        step();
        check_eq("t5_restart_y", mac.tile_y, 0);
        check_eq("t5_restart_x", mac.tile_x, 0);
        check_eq("t5_restart_valid", mac.tile_valid, 1);
        wait_idle("t5");
        check_eq("t5_restart_all", n_all, 1);
        check_eq("t5_restart_rows", n_row, 3);

        // Reset in WAIT_DONE coinciding with mac_done.
        clear_stats();
        auto_done = 1'b0;
        start = 1'b1;
        step();
        repeat (5) step();
        check_eq("t6_wait_valid", mac.tile_valid, 0);
        check_eq("t6_wait_busy", busy, 1);
        reset_in = 1'b1;
        mac.mac_done = 1'b1;
        step();
        check_all_zero("t6");
        reset_in = 1'b0;
        step();
        check_eq("t6_rows", n_row, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
